// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter
//   Round-robin arbiter that funnels NUM_CLIENTS request ports into one
//   memory request stream through a DEPTH-entry FIFO, and routes read
//   responses from memory back to per-client single-entry response slots.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cli_req_valid/write        per-client request valid and type (1 = write)
//   cli_req_addr/data          per-client address / write payload (slice i)
//   cli_req_ready              one-hot grant toward the clients
//   mem_req_*                  FIFO head presented to memory (valid/ready)
//   mem_rsp_*                  read response from memory (valid/ready, id, data)
//   cli_rsp_valid/ready/data   per-client response slot
//   fifo_count                 current FIFO occupancy
//   bad_id_err                 sticky flag: a response arrived with an unknown id
module memory_bus_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4,
  parameter int DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CLIENTS-1:0]        cli_req_valid,
  input  logic [NUM_CLIENTS-1:0]        cli_req_write,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_req_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cli_req_data,
  output logic [NUM_CLIENTS-1:0]        cli_req_ready,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_write,
  output logic [ADDR_W-1:0]             mem_req_addr,
  output logic [DATA_W-1:0]             mem_req_data,
  output logic [ID_W-1:0]               mem_req_id,
  input  logic                          mem_rsp_valid,
  output logic                          mem_rsp_ready,
  input  logic [ID_W-1:0]               mem_rsp_id,
  input  logic [DATA_W-1:0]             mem_rsp_data,
  output logic [NUM_CLIENTS-1:0]        cli_rsp_valid,
  input  logic [NUM_CLIENTS-1:0]        cli_rsp_ready,
  output logic [NUM_CLIENTS*DATA_W-1:0] cli_rsp_data,
  output logic [$clog2(DEPTH+1)-1:0]    fifo_count,
  output logic                          bad_id_err
);

  localparam int RR_W  = $clog2(NUM_CLIENTS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [RR_W-1:0]        r_rr;
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_fifoWrite [DEPTH];
  logic [ADDR_W-1:0]      r_fifoAddr  [DEPTH];
  logic [DATA_W-1:0]      r_fifoData  [DEPTH];
  logic [ID_W-1:0]        r_fifoId    [DEPTH];
  logic [NUM_CLIENTS-1:0] r_rspValid;
  logic [DATA_W-1:0]      r_rspData   [NUM_CLIENTS];
  logic                   r_badId;

  logic                   w_pop;
  logic                   w_push;
  logic                   w_canGrant;
  logic                   w_found;
  logic [RR_W-1:0]        w_grantIdx;
  logic [NUM_CLIENTS-1:0] w_grant;
  logic                   w_idInRange;
  logic                   w_slotBusy;
  logic                   w_rspAccept;

  // A full FIFO can still accept when its head leaves in the same cycle.
  // Gating with rst_n keeps every grant low while reset is held.
  assign w_pop      = mem_req_valid & mem_req_ready;
  assign w_canGrant = rst_n && ((r_count < CNT_W'(DEPTH)) || w_pop);

  // Search for the first valid client starting at the round-robin pointer.
  always_comb begin
    w_found    = 1'b0;
    w_grantIdx = '0;
    w_grant    = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (!w_found && cli_req_valid[(int'(r_rr) + k) % NUM_CLIENTS]) begin
        w_found    = 1'b1;
        w_grantIdx = RR_W'((int'(r_rr) + k) % NUM_CLIENTS);
      end
    end
    if (w_found && w_canGrant) begin
      w_grant[w_grantIdx] = 1'b1;
    end
  end

  assign cli_req_ready = w_grant;
  assign w_push        = |w_grant;

  // Pointer moves just past the winner so it gets lowest priority next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= '0;
    end else if (w_push) begin
      r_rr <= (int'(w_grantIdx) == NUM_CLIENTS - 1) ? '0 : w_grantIdx + RR_W'(1);
    end
  end

  // FIFO bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // FIFO storage holds no control state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoWrite[r_wptr] <= cli_req_write[w_grantIdx];
      r_fifoAddr[r_wptr]  <= cli_req_addr[int'(w_grantIdx)*ADDR_W +: ADDR_W];
      r_fifoData[r_wptr]  <= cli_req_data[int'(w_grantIdx)*DATA_W +: DATA_W];
      r_fifoId[r_wptr]    <= ID_W'(w_grantIdx);
    end
  end

  assign mem_req_valid = (r_count != '0);
  assign mem_req_write = r_fifoWrite[r_rptr];
  assign mem_req_addr  = r_fifoAddr[r_rptr];
  assign mem_req_data  = r_fifoData[r_rptr];
  assign mem_req_id    = r_fifoId[r_rptr];
  assign fifo_count    = r_count;

  // Decode the response id; unknown ids are always accepted so they drain.
  always_comb begin
    w_idInRange = 1'b0;
    w_slotBusy  = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (mem_rsp_id == ID_W'(i)) begin
        w_idInRange = 1'b1;
        w_slotBusy  = r_rspValid[i];
      end
    end
  end

  assign mem_rsp_ready = !w_slotBusy;
  assign w_rspAccept   = mem_rsp_valid & mem_rsp_ready;

  // A slot being drained is never the target of a load in the same cycle,
  // because the busy slot holds mem_rsp_ready low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspValid <= '0;
      r_badId    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (r_rspValid[i] && cli_rsp_ready[i]) begin
          r_rspValid[i] <= 1'b0;
        end else if (w_rspAccept && mem_rsp_id == ID_W'(i)) begin
          r_rspValid[i] <= 1'b1;
        end
      end
      if (w_rspAccept && !w_idInRange) begin
        r_badId <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (w_rspAccept && mem_rsp_id == ID_W'(i)) begin
        r_rspData[i] <= mem_rsp_data;
      end
    end
  end

  always_comb begin
    cli_rsp_data = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cli_rsp_data[i*DATA_W +: DATA_W] = r_rspData[i];
    end
  end

  assign cli_rsp_valid = r_rspValid;
  assign bad_id_err    = r_badId;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter
//   Self-checking bench for memory_bus_arbiter with a queue-based reference
//   model: a model process predicts grants and pushes expected FIFO entries
//   and responses; a monitor process pops and compares them when the DUT
//   presents a handshake.
module tb_memory_bus_arbiter;

  localparam int N     = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int IW    = 4;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [N-1:0]      cli_req_valid = '0;
  logic [N-1:0]      cli_req_write = '0;
  logic [N*AW-1:0]   cli_req_addr = '0;
  logic [N*DW-1:0]   cli_req_data = '0;
  logic [N-1:0]      cli_req_ready;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b1;
  logic              mem_req_write;
  logic [AW-1:0]     mem_req_addr;
  logic [DW-1:0]     mem_req_data;
  logic [IW-1:0]     mem_req_id;
  logic              mem_rsp_valid = 1'b0;
  logic              mem_rsp_ready;
  logic [IW-1:0]     mem_rsp_id = '0;
  logic [DW-1:0]     mem_rsp_data = '0;
  logic [N-1:0]      cli_rsp_valid;
  logic [N-1:0]      cli_rsp_ready = '1;
  logic [N*DW-1:0]   cli_rsp_data;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic              bad_id_err;

  memory_bus_arbiter #(
    .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cli_req_valid(cli_req_valid), .cli_req_write(cli_req_write),
    .cli_req_addr(cli_req_addr), .cli_req_data(cli_req_data),
    .cli_req_ready(cli_req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_id(mem_req_id),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_id(mem_rsp_id), .mem_rsp_data(mem_rsp_data),
    .cli_rsp_valid(cli_rsp_valid), .cli_rsp_ready(cli_rsp_ready),
    .cli_rsp_data(cli_rsp_data),
    .fifo_count(fifo_count), .bad_id_err(bad_id_err)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            id;
  } reqEntry_t;

  typedef struct {
    int            client;
    logic [DW-1:0] data;
  } rspEntry_t;

  int        nChecks = 0;
  int        nFails  = 0;
  reqEntry_t reqExpQ[$];
  rspEntry_t rspExpQ[$];

  int        mCount = 0;
  int        mRr    = 0;
  logic [N-1:0] mSlot = '0;
  logic      mBad   = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic reportMissing(input string name);
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s: actual=present expected=absent", name);
  endtask

  // Inputs change 1 ns after the rising edge and stay put until the next one.
  task automatic applyStimulus(input logic [N-1:0] vld, input logic memReady,
                               input logic rspValid, input logic [IW-1:0] rspId,
                               input logic [DW-1:0] rspData,
                               input logic [N-1:0] rspReady);
    @(posedge clk);
    #1;
    cli_req_valid = vld;
    cli_req_write = N'($urandom);
    cli_req_addr  = {$urandom, $urandom, $urandom, $urandom};
    cli_req_data  = {$urandom, $urandom, $urandom, $urandom};
    mem_req_ready = memReady;
    mem_rsp_valid = rspValid;
    mem_rsp_id    = rspId;
    mem_rsp_data  = rspData;
    cli_rsp_ready = rspReady;
  endtask

  // Reference model: on each falling edge, compare current state against the
  // model, then predict what the coming rising edge will transfer.
  always @(negedge clk) begin : modelProc
    int           pop;
    int           g;
    logic [N-1:0] expGrant;
    logic         expRspReady;
    logic [N-1:0] newSlot;
    reqEntry_t    e;
    rspEntry_t    r;
    if (!rst_n) begin
      mCount = 0;
      mRr    = 0;
      mSlot  = '0;
      mBad   = 1'b0;
      reqExpQ.delete();
      rspExpQ.delete();
      checkOutput("reset cli_req_ready", 64'(cli_req_ready), 64'd0);
      checkOutput("reset mem_req_valid", 64'(mem_req_valid), 64'd0);
      checkOutput("reset cli_rsp_valid", 64'(cli_rsp_valid), 64'd0);
      checkOutput("reset fifo_count", 64'(fifo_count), 64'd0);
      checkOutput("reset bad_id_err", 64'(bad_id_err), 64'd0);
    end else begin
      checkOutput("fifo_count", 64'(fifo_count), 64'(mCount));
      checkOutput("mem_req_valid", 64'(mem_req_valid), 64'(mCount != 0));
      checkOutput("cli_rsp_valid", 64'(cli_rsp_valid), 64'(mSlot));
      checkOutput("bad_id_err", 64'(bad_id_err), 64'(mBad));

      pop = (mCount != 0 && mem_req_ready) ? 1 : 0;
      g = -1;
      if (mCount < DEPTH || pop == 1) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && cli_req_valid[(mRr + k) % N]) g = (mRr + k) % N;
        end
      end
      expGrant = '0;
      if (g >= 0) expGrant[g] = 1'b1;
      checkOutput("cli_req_ready grant", 64'(cli_req_ready), 64'(expGrant));
      if (g >= 0) begin
        e.write = cli_req_write[g];
        e.addr  = cli_req_addr[g*AW +: AW];
        e.data  = cli_req_data[g*DW +: DW];
        e.id    = g;
        reqExpQ.push_back(e);
        mRr = (g + 1) % N;
      end
      mCount = mCount + ((g >= 0) ? 1 : 0) - pop;

      expRspReady = (int'(mem_rsp_id) < N) ? !mSlot[mem_rsp_id] : 1'b1;
      checkOutput("mem_rsp_ready", 64'(mem_rsp_ready), 64'(expRspReady));
      newSlot = mSlot;
      for (int i = 0; i < N; i++) begin
        if (mSlot[i] && cli_rsp_ready[i]) newSlot[i] = 1'b0;
      end
      if (mem_rsp_valid && expRspReady) begin
        if (int'(mem_rsp_id) < N) begin
          newSlot[mem_rsp_id] = 1'b1;
          r.client = int'(mem_rsp_id);
          r.data   = mem_rsp_data;
          rspExpQ.push_back(r);
        end else begin
          mBad = 1'b1;
        end
      end
      mSlot = newSlot;
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard heads.
  always @(negedge clk) begin : monitorProc
    int found;
    #1;
    if (rst_n) begin
      if (mem_req_valid) begin
        if (reqExpQ.size() == 0) begin
          reportMissing("mem_req_valid with empty scoreboard");
        end else begin
          checkOutput("mem_req_write", 64'(mem_req_write), 64'(reqExpQ[0].write));
          checkOutput("mem_req_addr", 64'(mem_req_addr), 64'(reqExpQ[0].addr));
          checkOutput("mem_req_data", 64'(mem_req_data), 64'(reqExpQ[0].data));
          checkOutput("mem_req_id", 64'(mem_req_id), 64'(reqExpQ[0].id));
          if (mem_req_ready) void'(reqExpQ.pop_front());
        end
      end
      for (int i = 0; i < N; i++) begin
        if (cli_rsp_valid[i] && cli_rsp_ready[i]) begin
          found = -1;
          for (int j = 0; j < rspExpQ.size(); j++) begin
            if (found < 0 && rspExpQ[j].client == i) found = j;
          end
          if (found < 0) begin
            reportMissing("cli_rsp_valid without expected response");
          end else begin
            checkOutput("cli_rsp_data", 64'(cli_rsp_data[i*DW +: DW]),
                        64'(rspExpQ[found].data));
            rspExpQ.delete(found);
          end
        end
      end
    end
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("init fifo_count", 64'(fifo_count), 64'd0);
    checkOutput("init mem_req_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("init bad_id_err", 64'(bad_id_err), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All clients requesting, memory always ready: grants rotate 0,1,2,3,0.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(4'hF, 1'b1, 1'b0, '0, '0, 4'hF);
      #1;
      checkOutput("rr grant order", 64'(cli_req_ready), 64'(4'b0001 << (k % 4)));
      if (k >= 1) begin
        checkOutput("rr mem_req_valid", 64'(mem_req_valid), 64'd1);
        checkOutput("rr mem_req_id", 64'(mem_req_id), 64'((k - 1) % 4));
      end
    end
    repeat (3) applyStimulus('0, 1'b1, 1'b0, '0, '0, 4'hF);

    // Memory stalled, client 2 fills the FIFO; one ready cycle pops and pushes.
    for (int k = 0; k < 6; k++) applyStimulus(4'b0100, 1'b0, 1'b0, '0, '0, 4'hF);
    #1;
    checkOutput("full fifo_count", 64'(fifo_count), 64'd4);
    checkOutput("full cli_req_ready", 64'(cli_req_ready), 64'd0);
    applyStimulus(4'b0100, 1'b1, 1'b0, '0, '0, 4'hF);
    #1;
    checkOutput("full pop+push grant", 64'(cli_req_ready), 64'b0100);
    applyStimulus(4'b0100, 1'b0, 1'b0, '0, '0, 4'hF);
    #1;
    checkOutput("full after pop+push", 64'(fifo_count), 64'd4);
    repeat (6) applyStimulus('0, 1'b1, 1'b0, '0, '0, 4'hF);

    // Response slot back-pressure on client 1.
    applyStimulus('0, 1'b1, 1'b1, 4'd1, 32'hCAFE, 4'h0);
    #1;
    checkOutput("rsp first ready", 64'(mem_rsp_ready), 64'd1);
    applyStimulus('0, 1'b1, 1'b1, 4'd1, 32'hBEEF, 4'h0);
    #1;
    checkOutput("rsp slot1 valid", 64'(cli_rsp_valid[1]), 64'd1);
    checkOutput("rsp slot1 data", 64'(cli_rsp_data[DW +: DW]), 64'hCAFE);
    checkOutput("rsp blocked", 64'(mem_rsp_ready), 64'd0);
    applyStimulus('0, 1'b1, 1'b1, 4'd1, 32'hBEEF, 4'b0010);
    #1;
    checkOutput("rsp blocked while draining", 64'(mem_rsp_ready), 64'd0);
    applyStimulus('0, 1'b1, 1'b1, 4'd1, 32'hBEEF, 4'h0);
    #1;
    checkOutput("rsp slot freed", 64'(mem_rsp_ready), 64'd1);
    applyStimulus('0, 1'b1, 1'b0, '0, '0, 4'h0);
    #1;
    checkOutput("rsp second data", 64'(cli_rsp_data[DW +: DW]), 64'hBEEF);
    repeat (2) applyStimulus('0, 1'b1, 1'b0, '0, '0, 4'hF);

    // Unknown response id is swallowed and flagged.
    applyStimulus('0, 1'b1, 1'b1, 4'd9, 32'h1234, 4'hF);
    #1;
    checkOutput("bad id accepted", 64'(mem_rsp_ready), 64'd1);
    applyStimulus('0, 1'b1, 1'b0, '0, '0, 4'hF);
    #1;
    checkOutput("bad id flag", 64'(bad_id_err), 64'd1);
    checkOutput("bad id no slot", 64'(cli_rsp_valid), 64'd0);
    repeat (5) applyStimulus('0, 1'b1, 1'b0, '0, '0, 4'hF);
    #1;
    checkOutput("bad id sticky", 64'(bad_id_err), 64'd1);

    // Randomized traffic.
    repeat (400) begin
      applyStimulus(N'($urandom), ($urandom % 4) != 0, 1'($urandom % 2),
                    IW'($urandom % N), DW'($urandom), N'($urandom));
    end
    repeat (10) applyStimulus('0, 1'b1, 1'b0, '0, '0, 4'hF);
    #1;
    checkOutput("request scoreboard drained", 64'(reqExpQ.size()), 64'd0);
    checkOutput("response scoreboard drained", 64'(rspExpQ.size()), 64'd0);

    // Reset mid-operation with three queued requests and slot 0 occupied.
    repeat (3) applyStimulus(4'b0001, 1'b0, 1'b0, '0, '0, 4'hF);
    applyStimulus('0, 1'b0, 1'b1, 4'd0, 32'h55AA, 4'h0);
    applyStimulus('0, 1'b0, 1'b0, '0, '0, 4'h0);
    #1;
    checkOutput("pre-reset fifo_count", 64'(fifo_count), 64'd3);
    checkOutput("pre-reset slot0", 64'(cli_rsp_valid), 64'b0001);
    cli_req_valid = 4'hF;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset fifo_count", 64'(fifo_count), 64'd0);
    checkOutput("async reset mem_req_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("async reset cli_rsp_valid", 64'(cli_rsp_valid), 64'd0);
    checkOutput("async reset cli_req_ready", 64'(cli_req_ready), 64'd0);
    checkOutput("async reset bad_id_err", 64'(bad_id_err), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_req_ready = 1'b1;
    cli_rsp_ready = 4'hF;
    #1;
    checkOutput("first grant after reset", 64'(cli_req_ready), 64'b0001);

    repeat (150) begin
      applyStimulus(N'($urandom), ($urandom % 3) != 0, 1'($urandom % 2),
                    IW'($urandom % N), DW'($urandom), N'($urandom));
    end
    repeat (10) applyStimulus('0, 1'b1, 1'b0, '0, '0, 4'hF);
    #1;
    checkOutput("final request scoreboard", 64'(reqExpQ.size()), 64'd0);
    checkOutput("final response scoreboard", 64'(rspExpQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
